bcd_digit_extractor: RTL



---
 rtl/gol_pkg.sv | 16 +
 rtl/bcd_digit_extractor_divide.sv | 34 +++
 rtl/bcd_digit_extractor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// Shared constants and types for the display-path conversion logic.
//   BCD_W   : bits per decimal digit
//   RADIX   : base used by the digit extractor
//   state_t : sequencing states of bcd_digit_extractor
package gol_pkg;

    localparam int BCD_W = 4;
    localparam int RADIX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : gol_pkg

// File: rtl/bcd_digit_extractor_divide.sv
// divide: combinational unsigned divider (restoring long division).
// Ports:
//   numerator   [NUM_W-1:0]  dividend
//   denominator [DEN_W-1:0]  divisor (must be non-zero)
//   quotient    [NUM_W-1:0]  numerator / denominator
//   remain      [DEN_W-1:0]  numerator % denominator
module divide #(
    parameter int NUM_W = 8,
    parameter int DEN_W = 4
) (
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remain
);

    // One extra bit: after the shift the partial remainder can reach
    // 2*denominator-1, which needs DEN_W+1 bits.
    logic [DEN_W:0] partial;

    always_comb begin
        partial  = '0;
        quotient = '0;
        for (int i = NUM_W - 1; i >= 0; i--) begin
            partial = {partial[DEN_W-1:0], numerator[i]};
            if (partial >= {1'b0, denominator}) begin
                partial     = partial - {1'b0, denominator};
                quotient[i] = 1'b1;
            end
        end
        remain = partial[DEN_W-1:0];
    end

endmodule : divide

// File: rtl/bcd_digit_extractor.sv
// bcd_digit_extractor: binary to packed BCD via repeated division by 10,
// one digit per clock, fixed latency of DIGITS cycles.
// Ports:
//   clk, rst_n  clock (rising edge) and async active-low reset
//   start       request; honoured only when idle
//   value       binary input, sampled on the accepted start
//   busy        high while digits are being extracted
//   done        one-cycle pulse with the new result
//   bcd         packed digits, digit 0 (units) in bcd[3:0]
//   blank       leading-zero mask, bit 0 never set
//   overflow    value did not fit in DIGITS decimal digits
// DIGITS must be at least 1.
module bcd_digit_extractor
    import gol_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]       blank,
    output logic                    overflow
);

    localparam int IDX_W    = $clog2(DIGITS + 1);
    localparam int BCD_BITS = BCD_W * DIGITS;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    state_t              state;
    logic [WIDTH-1:0]    work;
    logic [IDX_W-1:0]    idx;
    logic [BCD_BITS-1:0] shadow;
    logic [BCD_BITS-1:0] shadow_next;
    logic [DIGITS-1:0]   blank_next;
    logic                upper_zero;
    logic [WIDTH-1:0]    quotient;
    logic [BCD_W-1:0]    remain;

    divide #(
        .NUM_W(WIDTH),
        .DEN_W(BCD_W)
    ) u_divide (
        .numerator  (work),
        .denominator(BCD_W'(RADIX)),
        .quotient   (quotient),
        .remain     (remain)
    );

    // Shadow digits including the one being produced this cycle, so the
    // last division can load the outputs directly.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                shadow_next[i*BCD_W +: BCD_W] = remain;
            end
        end
    end

    // Scan from the most significant digit down; a digit is blanked while
    // it and everything above it is zero. The units digit is always lit.
    always_comb begin
        upper_zero = 1'b1;
        blank_next = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (shadow_next[i*BCD_W +: BCD_W] == '0);
            blank_next[i] = upper_zero;
        end
    end

    // State | meaning
    // IDLE  | waiting for start; outputs hold the last result
    // CONV  | one division per cycle, digit idx written to the shadow
    // DONE  | single cycle: done pulse and new result visible
    //
    // Outputs are registered, so the result is loaded on the edge that
    // enters DONE; it is therefore visible exactly while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            idx      <= '0;
            shadow   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work   <= value;
                        shadow <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    work   <= quotient;
                    shadow <= shadow_next;
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        bcd      <= shadow_next;
                        blank    <= blank_next;
                        // Anything left after DIGITS divisions did not fit.
                        overflow <= (quotient != '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : bcd_digit_extractor
